// File: rtl/v810_mem_slave_if.sv
// V810 data-bus signal bundle between the CPU bus initiator (master) and a memory responder (slave).
interface v810_mem_slave_if;
    logic [31:0] A;
    logic [31:0] D_I;
    logic [31:0] D_O;
    logic        D_OE;
    logic [3:0]  BEn;
    logic        MRQn;
    logic        DAn;
    logic        RW;
    logic        BCYSTn;
    logic        READYn;

    modport master (output A, D_I, BEn, MRQn, DAn, RW, BCYSTn,
                    input  D_O, D_OE, READYn);
    modport slave  (input  A, D_I, BEn, MRQn, DAn, RW, BCYSTn,
                    output D_O, D_OE, READYn);
endinterface

// File: rtl/v810_mem_slave.sv
// V810 data-bus memory responder: 2^AW x 32 word RAM, byte-lane writes, WAIT wait states before READYn.
// Optional V810_MEMSLV_STAT_EN adds RDCNT/WRCNT completed-cycle counters.
module v810_mem_slave #(
    parameter int          AW   = 10,
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int          WAIT = 0
) (
    input  logic CLK,
    input  logic RES,
    input  logic CE,
    v810_mem_slave_if.slave bus
`ifdef V810_MEMSLV_STAT_EN
    ,
    output logic [15:0] RDCNT,
    output logic [15:0] WRCNT
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    ben_q, ben_d;
    logic          rw_q, rw_d;
    logic [31:0]   dout_q, dout_d;

    logic [31:0]   mem [2**AW];

    logic          start_vld;
    logic [AW-1:0] a_idx;
    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetch_word;
    logic          wr_commit;
    logic          ack_exit;
    logic          unused_a;

    assign unused_a  = ^bus.A[1:0];
    assign a_idx     = bus.A[AW+1:2];
    assign start_vld = !bus.BCYSTn && !bus.MRQn && !bus.DAn
                       && (bus.A[31:AW+2] == BASE[31:AW+2]);
    assign ack_exit  = CE && (state_q == S_ACK);
    assign wr_commit = ack_exit && !rw_q;
    assign fetch_idx = (state_q == S_WAIT) ? idx_q : a_idx;

    // A read entering ACK on the same edge a write leaves it sees the written lanes.
    always_comb begin
        fetch_word = mem[fetch_idx];
        for (int i = 0; i < 4; i++) begin
            if (wr_commit && (idx_q == fetch_idx) && !ben_q[i])
                fetch_word[8*i +: 8] = bus.D_I[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ben_d   = ben_q;
        rw_d    = rw_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE, S_ACK: begin
                state_d = S_IDLE;
                if (start_vld) begin
                    idx_d = a_idx;
                    ben_d = bus.BEn;
                    rw_d  = bus.RW;
                    if (WAIT == 0) begin
                        state_d = S_ACK;
                        dout_d  = fetch_word;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    dout_d  = fetch_word;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ben_q   <= 4'hF;
            rw_q    <= 1'b0;
            dout_q  <= '0;
        end else if (CE) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ben_q   <= ben_d;
            rw_q    <= rw_d;
            dout_q  <= dout_d;
        end
    end

    // Memory is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge CLK) begin
        if (wr_commit && !RES) begin
            for (int i = 0; i < 4; i++) begin
                if (!ben_q[i])
                    mem[idx_q][8*i +: 8] <= bus.D_I[8*i +: 8];
            end
        end
    end

    assign bus.READYn = (state_q != S_ACK);
    assign bus.D_OE   = (state_q == S_ACK) && rw_q;
    assign bus.D_O    = bus.D_OE ? dout_q : 32'h0;

`ifdef V810_MEMSLV_STAT_EN
    logic [15:0] rdcnt_q, rdcnt_d;
    logic [15:0] wrcnt_q, wrcnt_d;

    always_comb begin
        rdcnt_d = rdcnt_q;
        wrcnt_d = wrcnt_q;
        if (ack_exit && rw_q)  rdcnt_d = rdcnt_q + 16'd1;
        if (ack_exit && !rw_q) wrcnt_d = wrcnt_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            rdcnt_q <= '0;
            wrcnt_q <= '0;
        end else begin
            rdcnt_q <= rdcnt_d;
            wrcnt_q <= wrcnt_d;
        end
    end

    assign RDCNT = rdcnt_q;
    assign WRCNT = wrcnt_q;
`endif
endmodule

// File: tb/tb_v810_mem_slave.sv
// Directed bench for v810_mem_slave: four instances (WAIT=0, WAIT=3, offset BASE, WAIT=5) on shared CPU-side stimulus.
module tb_v810_mem_slave;
    logic clk = 1'b0;
    logic rst;
    logic ce;
    always #5 clk = ~clk;

    logic [31:0] a, d_i;
    logic [3:0]  ben;
    logic        mrq_n, da_n, rw, bcyst_n;
    int          sel;
    logic        ready_n, d_oe;
    logic [31:0] d_o;
    logic [31:0] rdata;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n;
    int          saw_low;
    logic [15:0] rdc [4];
    logic [15:0] wrc [4];

    v810_mem_slave_if if0 ();
    v810_mem_slave_if if3 ();
    v810_mem_slave_if ifb ();
    v810_mem_slave_if if5 ();

    // Only the selected instance sees BCYSTn; the rest of the bus is shared.
    assign if0.A = a;  assign if0.D_I = d_i;  assign if0.BEn = ben;  assign if0.RW = rw;
    assign if0.MRQn = mrq_n;  assign if0.DAn = da_n;  assign if0.BCYSTn = (sel == 0) ? bcyst_n : 1'b1;
    assign if3.A = a;  assign if3.D_I = d_i;  assign if3.BEn = ben;  assign if3.RW = rw;
    assign if3.MRQn = mrq_n;  assign if3.DAn = da_n;  assign if3.BCYSTn = (sel == 1) ? bcyst_n : 1'b1;
    assign ifb.A = a;  assign ifb.D_I = d_i;  assign ifb.BEn = ben;  assign ifb.RW = rw;
    assign ifb.MRQn = mrq_n;  assign ifb.DAn = da_n;  assign ifb.BCYSTn = (sel == 2) ? bcyst_n : 1'b1;
    assign if5.A = a;  assign if5.D_I = d_i;  assign if5.BEn = ben;  assign if5.RW = rw;
    assign if5.MRQn = mrq_n;  assign if5.DAn = da_n;  assign if5.BCYSTn = (sel == 3) ? bcyst_n : 1'b1;

    always_comb begin
        ready_n = if0.READYn; d_oe = if0.D_OE; d_o = if0.D_O;
        case (sel)
            1: begin ready_n = if3.READYn; d_oe = if3.D_OE; d_o = if3.D_O; end
            2: begin ready_n = ifb.READYn; d_oe = ifb.D_OE; d_o = ifb.D_O; end
            3: begin ready_n = if5.READYn; d_oe = if5.D_OE; d_o = if5.D_O; end
            default: ;
        endcase
    end

`ifdef V810_MEMSLV_STAT_EN
    v810_mem_slave #(.AW(10), .BASE(32'h0), .WAIT(0)) dut0 (.CLK(clk), .RES(rst), .CE(ce), .bus(if0), .RDCNT(rdc[0]), .WRCNT(wrc[0]));
    v810_mem_slave #(.AW(10), .BASE(32'h0), .WAIT(3)) dut3 (.CLK(clk), .RES(rst), .CE(ce), .bus(if3), .RDCNT(rdc[1]), .WRCNT(wrc[1]));
    v810_mem_slave #(.AW(10), .BASE(32'h0500_0000), .WAIT(0)) dutb (.CLK(clk), .RES(rst), .CE(ce), .bus(ifb), .RDCNT(rdc[2]), .WRCNT(wrc[2]));
    v810_mem_slave #(.AW(10), .BASE(32'h0), .WAIT(5)) dut5 (.CLK(clk), .RES(rst), .CE(ce), .bus(if5), .RDCNT(rdc[3]), .WRCNT(wrc[3]));
`else
    v810_mem_slave #(.AW(10), .BASE(32'h0), .WAIT(0)) dut0 (.CLK(clk), .RES(rst), .CE(ce), .bus(if0));
    v810_mem_slave #(.AW(10), .BASE(32'h0), .WAIT(3)) dut3 (.CLK(clk), .RES(rst), .CE(ce), .bus(if3));
    v810_mem_slave #(.AW(10), .BASE(32'h0500_0000), .WAIT(0)) dutb (.CLK(clk), .RES(rst), .CE(ce), .bus(ifb));
    v810_mem_slave #(.AW(10), .BASE(32'h0), .WAIT(5)) dut5 (.CLK(clk), .RES(rst), .CE(ce), .bus(if5));
    initial begin
        for (int i = 0; i < 4; i++) begin rdc[i] = '0; wrc[i] = '0; end
    end
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One full bus cycle; latency counts edges after the edge that samples BCYSTn.
    task automatic bus_op(input string tag, input logic r, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int wt,
                          output logic [31:0] rd);
        int k;
        a = addr; d_i = wdata; ben = be; rw = r; mrq_n = 1'b0; da_n = 1'b0; bcyst_n = 1'b0;
        cyc();
        bcyst_n = 1'b1;
        k = 0;
        while (ready_n !== 1'b0 && k < 40) begin cyc(); k++; end
        chk({tag, "_lat"}, k, wt);
        chk({tag, "_oe"}, {31'h0, d_oe}, {31'h0, r});
        rd = d_o;
        cyc();
        chk({tag, "_end"}, {30'h0, ready_n, d_oe}, 32'h2);
        mrq_n = 1'b1; da_n = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; sel = 0;
        a = '0; d_i = '0; ben = 4'hF; rw = 1'b1; mrq_n = 1'b1; da_n = 1'b1; bcyst_n = 1'b1;
        cyc(); cyc();
        chk("rst_state", {ready_n, d_oe, d_o}, {1'b1, 1'b0, 32'h0});
        rst = 1'b0;
        cyc();

        // WAIT=0 write then read
        bus_op("w0_wr", 1'b0, 32'h10, 32'hDEADBEEF, 4'h0, 0, rdata);
        bus_op("w0_rd", 1'b1, 32'h10, 32'h0, 4'h0, 0, rdata);
        chk("w0_data", rdata, 32'hDEADBEEF);

        // Byte lanes, all-disabled write, A[1:0] ignored
        bus_op("bl_pre", 1'b0, 32'h40, 32'h11223344, 4'h0, 0, rdata);
        bus_op("bl_wr", 1'b0, 32'h40, 32'hAABBCCDD, 4'b1010, 0, rdata);
        bus_op("bl_rd", 1'b1, 32'h40, 32'h0, 4'h0, 0, rdata);
        chk("bl_data", rdata, 32'h11BB33DD);
        bus_op("bl_none", 1'b0, 32'h40, 32'h0, 4'hF, 0, rdata);
        bus_op("bl_rd2", 1'b1, 32'h43, 32'h0, 4'h0, 0, rdata);
        chk("bl_data2", rdata, 32'h11BB33DD);

        // Back-to-back write then read of index 5 with merge on the shared edge
        bus_op("b2b_pre", 1'b0, 32'h14, 32'h12345678, 4'h0, 0, rdata);
        a = 32'h14; d_i = 32'h0000FFFF; ben = 4'b1100; rw = 1'b0;
        mrq_n = 1'b0; da_n = 1'b0; bcyst_n = 1'b0;
        cyc();
        chk("b2b_wack", {30'h0, ready_n, d_oe}, 32'h0);
        rw = 1'b1;
        cyc();
        chk("b2b_rack", {30'h0, ready_n, d_oe}, 32'h1);
        chk("b2b_merge", d_o, 32'h1234FFFF);
        bcyst_n = 1'b1;
        cyc();
        chk("b2b_end", {ready_n, d_oe, d_o}, {1'b1, 1'b0, 32'h0});
        mrq_n = 1'b1; da_n = 1'b1;
        bus_op("b2b_rd", 1'b1, 32'h14, 32'h0, 4'h0, 0, rdata);
        chk("b2b_data", rdata, 32'h1234FFFF);

        // Start with MRQn=1 is ignored
        saw_low = 0;
        a = 32'h10; rw = 1'b1; mrq_n = 1'b1; da_n = 1'b0; bcyst_n = 1'b0;
        cyc();
        bcyst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin if (ready_n === 1'b0) saw_low = 1; cyc(); end
        chk("mrq_ignored", saw_low, 0);
        da_n = 1'b1;

        // WAIT=3, including a two-cycle CE stall mid-wait
        sel = 1;
        bus_op("w3_wr", 1'b0, 32'h8, 32'h0BADC0DE, 4'h0, 3, rdata);
        bus_op("w3_rd", 1'b1, 32'h8, 32'h0, 4'h0, 3, rdata);
        chk("w3_data", rdata, 32'h0BADC0DE);
        a = 32'h8; rw = 1'b1; mrq_n = 1'b0; da_n = 1'b0; bcyst_n = 1'b0;
        cyc();
        bcyst_n = 1'b1;
        cyc();
        ce = 1'b0;
        cyc(); cyc();
        chk("ce_frozen", {31'h0, ready_n}, 32'h1);
        ce = 1'b1;
        n = 0;
        while (ready_n !== 1'b0 && n < 40) begin cyc(); n++; end
        chk("ce_lat", 3 + n, 5);
        chk("ce_data", d_o, 32'h0BADC0DE);
        cyc();
        chk("ce_end", {31'h0, ready_n}, 32'h1);
        mrq_n = 1'b1; da_n = 1'b1;

        // Non-zero BASE: out-of-range start ignored, in-range completes
        sel = 2;
        saw_low = 0;
        a = 32'h0; rw = 1'b1; mrq_n = 1'b0; da_n = 1'b0; bcyst_n = 1'b0;
        cyc();
        bcyst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin if (ready_n === 1'b0) saw_low = 1; cyc(); end
        chk("oor_ignored", saw_low, 0);
        mrq_n = 1'b1; da_n = 1'b1;
        bus_op("base_wr", 1'b0, 32'h0500_0004, 32'h5A5A5A5A, 4'h0, 0, rdata);
        bus_op("base_rd", 1'b1, 32'h0500_0004, 32'h0, 4'h0, 0, rdata);
        chk("base_data", rdata, 32'h5A5A5A5A);

        // WAIT=5, reset two cycles into a write aborts without committing
        sel = 3;
        bus_op("rs_pre", 1'b0, 32'h20, 32'hCAFEF00D, 4'h0, 5, rdata);
        a = 32'h20; d_i = 32'h0; ben = 4'h0; rw = 1'b0; mrq_n = 1'b0; da_n = 1'b0; bcyst_n = 1'b0;
        cyc();
        bcyst_n = 1'b1;
        cyc(); cyc();
        rst = 1'b1;
        #1;
        chk("rs_abort", {30'h0, ready_n, d_oe}, 32'h2);
        cyc();
        rst = 1'b0;
        mrq_n = 1'b1; da_n = 1'b1;
        cyc();
        bus_op("rs_rd", 1'b1, 32'h20, 32'h0, 4'h0, 5, rdata);
        chk("rs_data", rdata, 32'hCAFEF00D);

`ifdef V810_MEMSLV_STAT_EN
        // Counters cleared by the reset above; count 2 writes and 3 reads on WAIT=0 instance
        sel = 0;
        bus_op("st_w1", 1'b0, 32'h80, 32'h1, 4'h0, 0, rdata);
        bus_op("st_w2", 1'b0, 32'h84, 32'h2, 4'h0, 0, rdata);
        bus_op("st_r1", 1'b1, 32'h80, 32'h0, 4'h0, 0, rdata);
        bus_op("st_r2", 1'b1, 32'h84, 32'h0, 4'h0, 0, rdata);
        bus_op("st_r3", 1'b1, 32'h80, 32'h0, 4'h0, 0, rdata);
        chk("st_rdcnt", {16'h0, rdc[0]}, 32'd3);
        chk("st_wrcnt", {16'h0, wrc[0]}, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
